// File: rtl/freelist_release_pkg.sv
// Shared types and sizing for the physical-register free list.
package freelist_release_pkg;

    localparam int PR_W     = 7;
    localparam int FL_DEPTH = 64;
    localparam int AR_NUM   = 32;
    localparam int IDX_W    = $clog2(FL_DEPTH);
    localparam int PTR_W    = IDX_W + 1;

    // Free-list pointer: MSB is the wrap bit, low bits index the tag array.
    typedef logic [PTR_W-1:0] fl_ptr_t;
    // Physical-register tag.
    typedef logic [PR_W-1:0]  pr_tag_t;

    // Write pointer starts one full lap ahead of the read pointer: list full.
    localparam fl_ptr_t WR_PTR_RESET = fl_ptr_t'(FL_DEPTH);

    // Array index carried by a pointer.
    function automatic logic [IDX_W-1:0] fl_index(input fl_ptr_t p);
        return p[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/freelist_tag_ram.sv
// 64-entry tag array: two write ports, four combinational read ports.
// Each entry resets to AR_NUM + index so the list starts holding the
// tags not mapped to architectural registers.
module freelist_tag_ram
    import freelist_release_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we0,
    input  logic [IDX_W-1:0] waddr0,
    input  pr_tag_t          wdata0,
    input  logic             we1,
    input  logic [IDX_W-1:0] waddr1,
    input  pr_tag_t          wdata1,
    input  logic [IDX_W-1:0] raddr0,
    input  logic [IDX_W-1:0] raddr1,
    input  logic [IDX_W-1:0] raddr2,
    input  logic [IDX_W-1:0] raddr3,
    output pr_tag_t          rdata0,
    output pr_tag_t          rdata1,
    output pr_tag_t          rdata2,
    output pr_tag_t          rdata3
);

    pr_tag_t entry_q [FL_DEPTH];

    generate
        for (genvar gi = 0; gi < FL_DEPTH; gi++) begin : g_entry
            pr_tag_t entry_reg;

            // One flop group per entry; the two write addresses never collide.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= PR_W'(AR_NUM + gi);
                end else if (we1 && (waddr1 == IDX_W'(gi))) begin
                    entry_reg <= wdata1;
                end else if (we0 && (waddr0 == IDX_W'(gi))) begin
                    entry_reg <= wdata0;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    assign rdata0 = entry_q[raddr0];
    assign rdata1 = entry_q[raddr1];
    assign rdata2 = entry_q[raddr2];
    assign rdata3 = entry_q[raddr3];

endmodule

// File: rtl/freelist_release.sv
// Free-list write side: captures freed tags at retire, compacts them,
// writes them into the tag array one cycle later and serves four
// allocation tags at the rename read pointer.
module freelist_release
    import freelist_release_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] retire_valid,
    input  logic [1:0] retire_has_dest,
    input  logic [6:0] retire_old_pr0,
    input  logic [6:0] retire_old_pr1,
    input  logic [6:0] rd_ptr,
    output logic [1:0] PR_num_wrback,
    output logic [6:0] alloc_pr0,
    output logic [6:0] alloc_pr1,
    output logic [6:0] alloc_pr2,
    output logic [6:0] alloc_pr3,
    output logic [6:0] wr_ptr_dbg
);

    logic [1:0]       live;
    logic [1:0]       count_next;
    pr_tag_t          tag0_next;
    pr_tag_t          tag1_next;
    logic [1:0]       count_reg;
    pr_tag_t          tag0_reg;
    pr_tag_t          tag1_reg;
    fl_ptr_t          wr_ptr_reg;
    fl_ptr_t          wr_ptr_next;
    logic [IDX_W-1:0] raddr [4];

    assign live = retire_valid & retire_has_dest;

    // Compaction: a lone slot-1 release moves to position 0.
    always_comb begin
        count_next = 2'(live[0]) + 2'(live[1]);
        tag0_next  = live[0] ? retire_old_pr0 : retire_old_pr1;
        tag1_next  = retire_old_pr1;
    end

    // Capture stage: count and compacted tags, write happens next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 2'd0;
            tag0_reg  <= '0;
            tag1_reg  <= '0;
        end else begin
            count_reg <= count_next;
            tag0_reg  <= tag0_next;
            tag1_reg  <= tag1_next;
        end
    end

    assign wr_ptr_next = wr_ptr_reg + fl_ptr_t'(count_reg);

    // Write pointer advances on the same edge as the array write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= WR_PTR_RESET;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_raddr
            assign raddr[gi] = fl_index(rd_ptr) + IDX_W'(gi);
        end
    endgenerate

    freelist_tag_ram u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we0    (count_reg != 2'd0),
        .waddr0 (fl_index(wr_ptr_reg)),
        .wdata0 (tag0_reg),
        .we1    (count_reg == 2'd2),
        .waddr1 (fl_index(wr_ptr_reg) + IDX_W'(1)),
        .wdata1 (tag1_reg),
        .raddr0 (raddr[0]),
        .raddr1 (raddr[1]),
        .raddr2 (raddr[2]),
        .raddr3 (raddr[3]),
        .rdata0 (alloc_pr0),
        .rdata1 (alloc_pr1),
        .rdata2 (alloc_pr2),
        .rdata3 (alloc_pr3)
    );

    assign PR_num_wrback = count_reg;
    assign wr_ptr_dbg    = wr_ptr_reg;

`ifndef SYNTHESIS
    // The list can never hold more than FL_DEPTH free tags.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        (count_reg != 2'd0) |-> (fl_ptr_t'(wr_ptr_next - rd_ptr) <= fl_ptr_t'(FL_DEPTH)));
`endif

endmodule

// File: tb/tb_freelist_release.sv
// Self-checking bench for freelist_release: behavioural free-list model,
// per-cycle compare, directed scenarios plus randomized retire traffic.
module tb_freelist_release;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] retire_valid = 2'b00;
    logic [1:0] retire_has_dest = 2'b00;
    logic [6:0] retire_old_pr0 = 7'd0;
    logic [6:0] retire_old_pr1 = 7'd0;
    logic [6:0] rd_ptr = 7'd0;
    logic [1:0] PR_num_wrback;
    logic [6:0] alloc_pr0, alloc_pr1, alloc_pr2, alloc_pr3;
    logic [6:0] wr_ptr_dbg;
    logic [6:0] alloc_v [4];

    int total_cnt = 0;
    int pass_cnt  = 0;

    freelist_release dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .retire_valid    (retire_valid),
        .retire_has_dest (retire_has_dest),
        .retire_old_pr0  (retire_old_pr0),
        .retire_old_pr1  (retire_old_pr1),
        .rd_ptr          (rd_ptr),
        .PR_num_wrback   (PR_num_wrback),
        .alloc_pr0       (alloc_pr0),
        .alloc_pr1       (alloc_pr1),
        .alloc_pr2       (alloc_pr2),
        .alloc_pr3       (alloc_pr3),
        .wr_ptr_dbg      (wr_ptr_dbg)
    );

    assign alloc_v[0] = alloc_pr0;
    assign alloc_v[1] = alloc_pr1;
    assign alloc_v[2] = alloc_pr2;
    assign alloc_v[3] = alloc_pr3;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: list of freed tags in order, landing in the array
    // one edge after capture.
    int         model_mem [64];
    logic [6:0] model_wr;
    int         pend [$];
    int         exp_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) model_mem[i] = 32 + i;
            model_wr = 7'd64;
            pend.delete();
            exp_cnt = 0;
        end else begin
            foreach (pend[j]) model_mem[(int'(model_wr) + j) % 64] = pend[j];
            model_wr = model_wr + 7'(pend.size());
            pend.delete();
            if (retire_valid[0] && retire_has_dest[0]) pend.push_back(int'(retire_old_pr0));
            if (retire_valid[1] && retire_has_dest[1]) pend.push_back(int'(retire_old_pr1));
            exp_cnt = pend.size();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_wrback", int'(PR_num_wrback), exp_cnt);
        chk("cyc_wr_ptr", int'(wr_ptr_dbg), int'(model_wr));
        for (int k = 0; k < 4; k++)
            chk($sformatf("cyc_alloc%0d", k), int'(alloc_v[k]), model_mem[(int'(rd_ptr) + k) % 64]);
    end

    task automatic step(input logic [1:0] v, input logic [1:0] hd,
                        input logic [6:0] t0, input logic [6:0] t1, input logic [6:0] rd);
        retire_valid    = v;
        retire_has_dest = hd;
        retire_old_pr0  = t0;
        retire_old_pr1  = t1;
        rd_ptr          = rd;
        $display("txn t=%0t valid=%b has_dest=%b pr0=%0d pr1=%0d rd_ptr=%0d",
                 $time, v, hd, t0, t1, rd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [6:0] rd);
        step(2'b00, 2'b00, 7'd0, 7'd0, rd);
    endtask

    initial begin
        logic [1:0] v, hd;
        logic [6:0] start;
        int rem, n;

        // 1: reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_wrback", int'(PR_num_wrback), 0);
        chk("rst_wr_ptr", int'(wr_ptr_dbg), 64);
        chk("rst_alloc0", int'(alloc_pr0), 32);
        chk("rst_alloc1", int'(alloc_pr1), 33);
        chk("rst_alloc2", int'(alloc_pr2), 34);
        chk("rst_alloc3", int'(alloc_pr3), 35);

        // 2: two releases
        step(2'b11, 2'b11, 7'd40, 7'd41, 7'd64);
        chk("two_wrback", int'(PR_num_wrback), 2);
        idle(7'd64);
        chk("two_wr_ptr", int'(wr_ptr_dbg), 66);
        chk("two_alloc0", int'(alloc_pr0), 40);
        chk("two_alloc1", int'(alloc_pr1), 41);
        chk("two_alloc2", int'(alloc_pr2), 34);
        chk("two_alloc3", int'(alloc_pr3), 35);

        // 3: compaction of a lone slot-1 release
        step(2'b11, 2'b10, 7'd55, 7'd77, 7'd64);
        chk("cmp_wrback", int'(PR_num_wrback), 1);
        idle(7'd66);
        chk("cmp_wr_ptr", int'(wr_ptr_dbg), 67);
        chk("cmp_alloc0", int'(alloc_pr0), 77);
        chk("cmp_alloc1", int'(alloc_pr1), 35);

        // Random retire traffic with a trailing allocator pointer
        repeat (300) begin
            v  = 2'($urandom);
            if (v[1]) v[0] = 1'b1;
            hd = 2'($urandom);
            step(v, hd, 7'($urandom), 7'($urandom), model_wr - 7'($urandom_range(0, 60)));
        end

        // 4: steer the write pointer to 63, then wrap
        idle(model_wr);
        idle(model_wr);
        rem = int'(7'(7'd63 - model_wr));
        while (rem > 0) begin
            n = (rem >= 2) ? 2 : 1;
            step((n == 2) ? 2'b11 : 2'b01, 2'b11, 7'($urandom), 7'($urandom), model_wr);
            rem -= n;
        end
        idle(model_wr);
        chk("wrap_pre_ptr", int'(wr_ptr_dbg), 63);
        step(2'b11, 2'b11, 7'd5, 7'd6, 7'd63);
        chk("wrap_wrback", int'(PR_num_wrback), 2);
        idle(7'd63);
        chk("wrap_wr_ptr", int'(wr_ptr_dbg), 65);
        chk("wrap_alloc0", int'(alloc_pr0), 5);
        chk("wrap_alloc1", int'(alloc_pr1), 6);

        // 5: back-to-back pairs, four cycles
        start = model_wr;
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 2'b11, 7'(100 + 2 * i), 7'(101 + 2 * i), start);
            chk($sformatf("b2b_wrback%0d", i), int'(PR_num_wrback), 2);
        end
        idle(start);
        chk("b2b_wrback_end", int'(PR_num_wrback), 0);
        chk("b2b_wr_ptr", int'(wr_ptr_dbg), int'(7'(start + 7'd8)));
        for (int k = 0; k < 4; k++)
            chk($sformatf("b2b_lo%0d", k), int'(alloc_v[k]), 100 + k);
        rd_ptr = start + 7'd4;
        #1;
        for (int k = 0; k < 4; k++)
            chk($sformatf("b2b_hi%0d", k), int'(alloc_v[k]), 104 + k);

        // 6: reset while a pair is waiting to be written
        step(2'b11, 2'b11, 7'd20, 7'd21, model_wr);
        chk("rmid_wrback_pre", int'(PR_num_wrback), 2);
        #1;
        rst_n  = 1'b0;
        rd_ptr = 7'd0;
        #1;
        chk("rmid_wrback", int'(PR_num_wrback), 0);
        chk("rmid_wr_ptr", int'(wr_ptr_dbg), 64);
        for (int k = 0; k < 4; k++)
            chk($sformatf("rmid_alloc%0d", k), int'(alloc_v[k]), 32 + k);
        retire_valid    = 2'b00;
        retire_has_dest = 2'b00;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int s = 0; s < 16; s++) begin
            idle(7'(4 * s));
            for (int k = 0; k < 4; k++)
                chk($sformatf("rmid_sweep%0d", 4 * s + k), int'(alloc_v[k]), 32 + 4 * s + k);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
